// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter folding NUM_REQ functional-unit
// completion streams onto up to three registered writeback buses.
//
// Handshake: a requester offers a payload with req_valid[i]. The arbiter
// answers combinationally with req_ready[i]. A transfer happens at a rising
// edge where both are high. The payload then sits on its bus, with the valid
// bit set, for exactly the following cycle. Buses that take no transfer at an
// edge are registered to all zeros, so a bus never carries stale data.
module wb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PAYLOAD_W = 56
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [2:0]                     bus_en,
    input  logic                           stall,
    output logic [PAYLOAD_W:0]             bus0,
    output logic [PAYLOAD_W:0]             bus1,
    output logic [PAYLOAD_W:0]             bus2,
    output logic [15:0]                    conflict_cnt,
    // Current highest-priority requester; exported so checkers can follow the rotation.
    output logic [$clog2(NUM_REQ)-1:0]     rr_ptr
);

    localparam int                PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W:0]    NREQ  = (PTR_W+1)'(NUM_REQ);
    localparam int                NBUS  = 3;

    // Architectural state
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PAYLOAD_W:0]   bus_q [NBUS];
    logic [PAYLOAD_W:0]   bus_d [NBUS];
    logic [15:0]          conflict_q, conflict_d;

    // Arbitration results. A slot is the ordinal position of a grant (first,
    // second, third) before it is mapped onto a physical bus.
    logic [1:0]           n_bus;
    logic [NUM_REQ-1:0]   grant;
    logic [1:0]           grant_cnt;
    logic [PTR_W-1:0]     last_idx;
    logic [NBUS-1:0]      slot_valid;
    logic [PAYLOAD_W-1:0] slot_data [NBUS];
    logic [3:0]           req_cnt;
    logic                 conflict;

    // Number of buses available this cycle
    always_comb begin
        n_bus = {1'b0, bus_en[0]} + {1'b0, bus_en[1]} + {1'b0, bus_en[2]};
    end

    // Round-robin scan starting at rr_ptr, granting valid requesters into successive slots
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        grant      = '0;
        grant_cnt  = 2'd0;
        last_idx   = rr_ptr_q;
        slot_valid = '0;
        for (int s = 0; s < NBUS; s++) begin
            slot_data[s] = '0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = sum[PTR_W-1:0];
            // Each requester is visited once, so it can win at most one slot.
            if (rst_n && !stall && req_valid[idx] && (grant_cnt < n_bus)) begin
                grant[idx]             = 1'b1;
                slot_valid[grant_cnt]  = 1'b1;
                slot_data[grant_cnt]   = req_data[idx*PAYLOAD_W +: PAYLOAD_W];
                last_idx               = idx;
                grant_cnt              = grant_cnt + 2'd1;
            end
        end
    end

    assign req_ready = grant;

    // Map slots onto enabled buses in ascending bus order; everything else clears
    always_comb begin
        logic [1:0] slot;
        slot = 2'd0;
        for (int b = 0; b < NBUS; b++) begin
            bus_d[b] = '0;
            if (bus_en[b]) begin
                if (slot_valid[slot]) begin
                    bus_d[b] = {1'b1, slot_data[slot]};
                end
                slot = slot + 2'd1;
            end
        end
    end

    // Next priority pointer: one past the last winner, or hold if nobody won
    always_comb begin
        logic [PTR_W:0] nxt;
        nxt      = {1'b0, last_idx} + {{PTR_W{1'b0}}, 1'b1};
        if (nxt >= NREQ) begin
            nxt = nxt - NREQ;
        end
        rr_ptr_d = rr_ptr_q;
        if (grant_cnt != 2'd0) begin
            rr_ptr_d = nxt[PTR_W-1:0];
        end
    end

    // Conflict detection: more requests pending than were granted, saturating count
    always_comb begin
        req_cnt = 4'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_cnt = req_cnt + {3'b000, req_valid[i]};
        end
        conflict   = (req_cnt > {2'b00, grant_cnt});
        conflict_d = conflict_q;
        if (conflict && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    // State registers; reset clears everything immediately, independent of clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            conflict_q <= '0;
            for (int b = 0; b < NBUS; b++) begin
                bus_q[b] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            conflict_q <= conflict_d;
            for (int b = 0; b < NBUS; b++) begin
                bus_q[b] <= bus_d[b];
            end
        end
    end

    assign bus0         = bus_q[0];
    assign bus1         = bus_q[1];
    assign bus2         = bus_q[2];
    assign conflict_cnt = conflict_q;
    assign rr_ptr       = rr_ptr_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a
// queue-based reference model of the round-robin writeback rules.
module tb_wb_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int PAYLOAD_W = 56;
  localparam int BW        = PAYLOAD_W + 1;

  // ---------------- clock / reset / DUT ----------------
  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*PAYLOAD_W-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic [2:0]                   bus_en;
  logic                         stall;
  logic [BW-1:0]                bus0, bus1, bus2;
  logic [15:0]                  conflict_cnt;
  logic [1:0]                   rr_ptr;

  logic [PAYLOAD_W-1:0]         pay [NUM_REQ];

  always #5 clk = ~clk;

  assign req_data = {pay[3], pay[2], pay[1], pay[0]};

  wb_arbiter #(.NUM_REQ(NUM_REQ), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .bus_en       (bus_en),
    .stall        (stall),
    .bus0         (bus0),
    .bus1         (bus1),
    .bus2         (bus2),
    .conflict_cnt (conflict_cnt),
    .rr_ptr       (rr_ptr)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            m_rr  = 0;
  int            m_cnt = 0;
  logic [3:0]    nx_ready;
  int            nx_rr;
  int            nx_cnt;
  logic [BW-1:0] nx_bus [3];

  // Grants: walk requesters from the pointer, take the first valid ones up to
  // the number of enabled buses, hand them out to enabled buses lowest first.
  task automatic model(input logic [3:0] v, input logic [2:0] en, input logic st);
    int buses[$];
    int granted[$];
    int i;
    nx_ready = '0;
    for (int b = 0; b < 3; b++) nx_bus[b] = '0;
    for (int b = 0; b < 3; b++) if (en[b]) buses.push_back(b);
    if (!st) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        i = (m_rr + k) % NUM_REQ;
        if (v[i] && granted.size() < buses.size()) granted.push_back(i);
      end
    end
    foreach (granted[j]) begin
      nx_ready[granted[j]] = 1'b1;
      nx_bus[buses[j]]     = {1'b1, pay[granted[j]]};
    end
    nx_rr  = (granted.size() > 0) ? (granted[granted.size()-1] + 1) % NUM_REQ : m_rr;
    nx_cnt = ($countones(v) > granted.size() && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
  endtask

  // ---------------- driver ----------------
  // Entered just after a rising edge; leaves just after the next one.
  task automatic step(input logic [3:0] v, input logic [2:0] en, input logic st);
    logic [BW-1:0] e;
    req_valid = v;
    bus_en    = en;
    stall     = st;
    @(negedge clk);
    model(v, en, st);
    check("req_ready", 64'(req_ready), 64'(nx_ready));
    @(posedge clk);
    #1;
    m_rr  = nx_rr;
    m_cnt = nx_cnt;
    for (int b = 0; b < 3; b++) exp_q.push_back(nx_bus[b]);
    e = exp_q.pop_front(); check("bus0", 64'(bus0), 64'(e));
    e = exp_q.pop_front(); check("bus1", 64'(bus1), 64'(e));
    e = exp_q.pop_front(); check("bus2", 64'(bus2), 64'(e));
    check("rr_ptr", 64'(rr_ptr), 64'(m_rr));
    check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
  endtask

  task automatic rand_payloads();
    for (int i = 0; i < NUM_REQ; i++) pay[i] = PAYLOAD_W'({$urandom(), $urandom()});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    bus_en    = 3'b111;
    stall     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) pay[i] = PAYLOAD_W'(8'hA0 + i);

    // Reset asserted asynchronously; outputs and ready must read zero while low
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_bus0", 64'(bus0), 64'd0);
    check("rst_rr", 64'(rr_ptr), 64'd0);
    check("rst_cnt", 64'(conflict_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus1_hold", 64'(bus1), 64'd0);
    rst_n = 1'b1;
    m_rr  = 0;
    m_cnt = 0;

    // Four requesters, three buses: 0,1,2 then 3,0,1
    step(4'b1111, 3'b111, 1'b0);
    check("dir_bus0_A0", 64'(bus0), {7'd0, 1'b1, 56'hA0});
    step(4'b1111, 3'b111, 1'b0);
    check("dir_bus0_A3", 64'(bus0), {7'd0, 1'b1, 56'hA3});
    check("dir_rr_2", 64'(rr_ptr), 64'd2);

    // Bring the pointer back to 0, then sparse bus enable
    step(4'b1000, 3'b111, 1'b0);
    step(4'b0110, 3'b101, 1'b0);
    check("sparse_bus1_zero", 64'(bus1), 64'd0);
    check("sparse_bus2_A2", 64'(bus2), {7'd0, 1'b1, 56'hA2});

    // Stall three cycles with a pending request, then release
    repeat (3) step(4'b0001, 3'b111, 1'b1);
    step(4'b0001, 3'b111, 1'b0);
    check("post_stall_bus0", 64'(bus0), {7'd0, 1'b1, 56'hA0});

    // No buses enabled at all
    step(4'b0101, 3'b000, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rand_payloads();
      step(4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111,
           ($urandom_range(0, 7) == 0));
    end

    // Starvation bound with one bus: each of four always-valid requesters in four cycles
    begin
      logic [3:0] seen;
      seen = '0;
      for (int n = 0; n < NUM_REQ; n++) begin
        req_valid = 4'b1111; bus_en = 3'b010; stall = 1'b0;
        @(negedge clk);
        seen = seen | req_ready;
        @(posedge clk);
        #1;
        m_rr = (m_rr + 1) % NUM_REQ;
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      end
      check("starve_all_served", 64'(seen), 64'hF);
    end

    // Asynchronous reset mid-cycle while buses are valid
    rand_payloads();
    step(4'b1111, 3'b111, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_bus0", 64'(bus0), 64'd0);
    check("async_bus2", 64'(bus2), 64'd0);
    check("async_rr", 64'(rr_ptr), 64'd0);
    check("async_cnt", 64'(conflict_cnt), 64'd0);
    check("async_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("discard_bus0", 64'(bus0), 64'd0);
    rst_n = 1'b1;
    m_rr  = 0;
    m_cnt = 0;

    // Saturation: drive the counter to FFFE with stalled requests, then past the top
    req_valid = 4'b0001; bus_en = 3'b111; stall = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("cnt_fffe", 64'(conflict_cnt), 64'hFFFE);
    m_cnt = 65534;
    step(4'b0001, 3'b111, 1'b1);
    step(4'b0001, 3'b111, 1'b1);
    check("cnt_sat", 64'(conflict_cnt), 64'hFFFF);
    step(4'b0011, 3'b111, 1'b1);
    step(4'b0001, 3'b111, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
